alu_sync: RTL and testbench



---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_if.sv | 26 ++
 rtl/alu_comb.sv | 82 ++++++++
 rtl/alu_sync.sv | 56 +++++
 tb/tb_alu_sync.sv | 118 +++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and flag bundle shared by the alu_sync slice
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_ROR = 4'd10;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/opcode and result/flag bundle around alu_sync
interface alu_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             overflow;

  // Master issues operations and observes the registered outputs
  modport master (
    output a, b, opcode,
    input  result, carry, zero, overflow
  );

  // Slave is the ALU itself
  modport slave (
    input  a, b, opcode,
    output result, carry, zero, overflow
  );

endinterface

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - combinational next-result/flags logic; ALU_ROTATE_EN enables ROL/ROR on opcodes 9/10
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_opcode,
  output logic [WIDTH-1:0] o_result,
  output alu_flags_t       o_flags
);

  // One extra bit on each arithmetic path catches the carry/borrow out
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_inc  = {1'b0, i_a} + {{WIDTH{1'b0}}, 1'b1};

  // Opcode decode; anything not decoded yields a zero result with clear flags
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_AND: w_res = i_a & i_b;
      OP_OR:  w_res = i_a | i_b;
      OP_XOR: w_res = i_a ^ i_b;
      OP_NOT: w_res = ~i_a;
      OP_SHL: begin
        w_res = {i_a[WIDTH-2:0], 1'b0};
        w_c   = i_a[WIDTH-1];
      end
      OP_SHR: begin
        w_res = {1'b0, i_a[WIDTH-1:1]};
        w_c   = i_a[0];
      end
      OP_INC: begin
        w_res = w_inc[WIDTH-1:0];
        w_c   = w_inc[WIDTH];
        w_v   = (i_a == {1'b0, {(WIDTH-1){1'b1}}});
      end
`ifdef ALU_ROTATE_EN
      OP_ROL: begin
        w_res = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
        w_c   = i_a[WIDTH-1];
      end
      OP_ROR: begin
        w_res = {i_a[0], i_a[WIDTH-1:1]};
        w_c   = i_a[0];
      end
`endif
      default: begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
    endcase
  end

  assign o_result         = w_res;
  assign o_flags.carry    = w_c;
  assign o_flags.zero     = (w_res == '0);
  assign o_flags.overflow = w_v;

endmodule

// File: rtl/alu_sync.sv
// rtl/alu_sync.sv - registered 8-bit ALU top; ALU_ROTATE_EN adds ROL/ROR via alu_comb
module alu_sync
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] w_result;
  alu_flags_t       w_flags;

  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_overflow;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .i_a      (a),
    .i_b      (b),
    .i_opcode (opcode),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  // Capture one operation per clock; reset clears everything, including zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_result   <= w_result;
      r_carry    <= w_flags.carry;
      r_zero     <= w_flags.zero;
      r_overflow <= w_flags.overflow;
    end
  end

  assign result   = r_result;
  assign carry    = r_carry;
  assign zero     = r_zero;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_alu_sync.sv
// tb/tb_alu_sync.sv - scoreboard bench for alu_sync; ALU_ROTATE_EN selects rotate expectations
module tb_alu_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_if #(.WIDTH(8)) bus ();

  alu_sync #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (bus.a),
    .b        (bus.b),
    .opcode   (bus.opcode),
    .result   (bus.result),
    .carry    (bus.carry),
    .zero     (bus.zero),
    .overflow (bus.overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       v;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic apply(input logic rs, input logic [7:0] ta, input logic [7:0] tb,
                       input logic [3:0] op, input string nm,
                       input logic [7:0] er, input logic ec, input logic ez, input logic ev);
    exp_t e;
    @(negedge clk);
    rst        = rs;
    bus.a      = ta;
    bus.b      = tb;
    bus.opcode = op;
    e.name = nm;
    e.r    = er;
    e.c    = ec;
    e.z    = ez;
    e.v    = ev;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are due one edge after issue, sampled just past the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.result !== e.r || bus.carry !== e.c || bus.zero !== e.z || bus.overflow !== e.v) begin
          n_bad++;
          $display("FAIL %s: got r=%02h c=%b z=%b v=%b, want r=%02h c=%b z=%b v=%b",
                   e.name, bus.result, bus.carry, bus.zero, bus.overflow, e.r, e.c, e.z, e.v);
        end
      end
    end
  end

  initial begin
    bus.a      = 8'h00;
    bus.b      = 8'h00;
    bus.opcode = 4'h0;
    // Reset held for two edges
    apply(1'b1, 8'h66, 8'h55, 4'd0, "reset0", 8'h00, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 8'h66, 8'h55, 4'd0, "reset1", 8'h00, 1'b0, 1'b0, 1'b0);
    // Back-to-back opcodes 0..8 with a=0x66 b=0x55
    apply(1'b0, 8'h66, 8'h55, 4'd0, "add",  8'hBB, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 8'h66, 8'h55, 4'd1, "sub",  8'h11, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 8'h66, 8'h55, 4'd2, "and",  8'h44, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 8'h66, 8'h55, 4'd3, "or",   8'h77, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 8'h66, 8'h55, 4'd4, "xor",  8'h33, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 8'h66, 8'h55, 4'd5, "not",  8'h99, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 8'h66, 8'h55, 4'd6, "shl",  8'hCC, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 8'h66, 8'h55, 4'd7, "shr",  8'h33, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 8'h66, 8'h55, 4'd8, "inc",  8'h67, 1'b0, 1'b0, 1'b0);
    // Boundary cases
    apply(1'b0, 8'hFF, 8'h01, 4'd0, "add_wrap",  8'h00, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 8'h00, 8'h01, 4'd1, "sub_borrow", 8'hFF, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 8'h7F, 8'h55, 4'd8, "inc_ovf",   8'h80, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 8'h80, 8'h01, 4'd1, "sub_ovf",   8'h7F, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 8'hFF, 8'h00, 4'd8, "inc_wrap",  8'h00, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 8'h81, 8'h00, 4'd6, "shl_out",   8'h02, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 8'h81, 8'h00, 4'd7, "shr_out",   8'h40, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 8'h66, 8'h55, 4'hF, "op_f",      8'h00, 1'b0, 1'b1, 1'b0);
`ifdef ALU_ROTATE_EN
    apply(1'b0, 8'h81, 8'h00, 4'd9,  "rol",      8'h03, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 8'h81, 8'h00, 4'd10, "ror",      8'hC0, 1'b1, 1'b0, 1'b0);
`else
    apply(1'b0, 8'h81, 8'h00, 4'd9,  "op9",      8'h00, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 8'h81, 8'h00, 4'd10, "op10",     8'h00, 1'b0, 1'b1, 1'b0);
`endif
    // Reset mid-stream beats the opcode, next op registers right after
    apply(1'b1, 8'h66, 8'h55, 4'd0, "rst_mid",   8'h00, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 8'h66, 8'h55, 4'd0, "after_rst", 8'hBB, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 8'h66, 8'h55, 4'd0, "add_again", 8'hBB, 1'b0, 1'b0, 1'b1);
    // Drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
